// File: rtl/vr_rr_arbiter_if.sv
// vr_rr_arbiter_if: bundles the N upstream valid/ready channels, the single
// downstream valid/ready channel and the grant status of vr_rr_arbiter.
//   master modport : the side that drives requests and downstream ready
//   slave  modport : the arbiter itself
interface vr_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int DW  = 8,
  parameter int IDW = 2
);

  logic [N-1:0]    s_valid;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_ready;
  logic [N-1:0]    grant_oh;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, grant_oh, grant_id, busy
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, grant_oh, grant_id, busy
  );

endinterface

// File: rtl/vr_rr_arbiter.sv
// vr_rr_arbiter: round-robin arbiter sharing one valid/ready downstream
// channel among N valid/ready masters. A grant is locked from the moment it
// is issued until the granted beat handshakes, so a master's beat is never
// cut off. The most recently served master has lowest priority next time.
//
// Optional feature macro: VR_ARB_BURST_EN
//   undefined : one beat per grant, release to IDLE after every handshake.
//   defined   : up to BURST_MAX back-to-back beats per grant; the grant is
//               released on the BURST_MAX-th beat or when the granted master
//               drops valid after at least one beat.
module vr_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int IDW       = 2,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  vr_rr_arbiter_if.slave   bus
);

  // Elaboration-time sanity checks on the configuration.
  if (IDW != $clog2(N)) begin : g_bad_idw
    $error("vr_rr_arbiter: IDW must equal clog2(N)");
  end
  if ((N < 2) || (N > 16)) begin : g_bad_n
    $error("vr_rr_arbiter: N must lie in 2..16");
  end
  if (BURST_MAX < 1) begin : g_bad_burst
    $error("vr_rr_arbiter: BURST_MAX must be at least 1");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

`ifdef VR_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_MAX + 1);
`endif

  // ---------------------------------------------------------------------
  // Rotating priority pick: first requester strictly above 'last', else
  // the lowest-numbered requester (wrap-around). Scanning downward lets
  // the final assignment be the lowest matching index.
  // ---------------------------------------------------------------------
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   req,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] first_any;
    logic [IDW-1:0] first_above;
    logic           have_above;
    first_any   = last;
    first_above = last;
    have_above  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        first_any = IDW'(i);
        if (i > int'(last)) begin
          first_above = IDW'(i);
          have_above  = 1'b1;
        end else begin
          have_above  = have_above;
        end
      end else begin
        first_any = first_any;
      end
    end
    return have_above ? first_above : first_any;
  endfunction

  // One-hot encode of a master index.
  function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDW'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t         state_r;
  logic [N-1:0]   grant_oh_r;
  logic [IDW-1:0] grant_id_r;
  logic [IDW-1:0] last_r;
  logic           busy_r;
`ifdef VR_ARB_BURST_EN
  logic [BCW-1:0] beat_cnt_r;
`endif

  logic [IDW-1:0] winner_s;
  logic           sel_valid_s;
  logic           hs_s;
  logic [N-1:0]   s_ready_s;
  logic           m_valid_s;
  logic [DW-1:0]  m_data_s;

  assign winner_s = rr_pick(bus.s_valid, last_r);

  // Forward the granted master's beat to the downstream slave while in GRANT.
  always_comb begin
    sel_valid_s = 1'b0;
    m_data_s    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh_r[i]) begin
        sel_valid_s = bus.s_valid[i];
        m_data_s    = bus.s_data[i*DW +: DW];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
    if (state_r == GRANT) begin
      m_valid_s = sel_valid_s;
      s_ready_s = grant_oh_r & {N{bus.m_ready}};
    end else begin
      m_valid_s = 1'b0;
      m_data_s  = '0;
      s_ready_s = '0;
    end
  end

  assign hs_s = m_valid_s & bus.m_ready;

  // Arbitration and grant-lock state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      grant_oh_r <= '0;
      grant_id_r <= LAST_RST;
      last_r     <= LAST_RST;
      busy_r     <= 1'b0;
`ifdef VR_ARB_BURST_EN
      beat_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.s_valid) begin
            grant_oh_r <= to_onehot(winner_s);
            grant_id_r <= winner_s;
            busy_r     <= 1'b1;
            state_r    <= GRANT;
          end else begin
            state_r    <= IDLE;
          end
        end
        GRANT: begin
`ifdef VR_ARB_BURST_EN
          if (hs_s) begin
            if ((int'(beat_cnt_r) + 1) < BURST_MAX) begin
              beat_cnt_r <= beat_cnt_r + BCW'(1);
            end else begin
              beat_cnt_r <= '0;
              last_r     <= grant_id_r;
              grant_oh_r <= '0;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end
          end else if ((beat_cnt_r != '0) && !sel_valid_s) begin
            // Master ended its burst early: give the channel back.
            beat_cnt_r <= '0;
            last_r     <= grant_id_r;
            grant_oh_r <= '0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r    <= GRANT;
          end
`else
          if (hs_s) begin
            last_r     <= grant_id_r;
            grant_oh_r <= '0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            // Locked until the beat handshakes, even if valid drops.
            state_r    <= GRANT;
          end
`endif
        end
        default: begin
          state_r    <= IDLE;
          grant_oh_r <= '0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready  = s_ready_s;
  assign bus.m_valid  = m_valid_s;
  assign bus.m_data   = m_data_s;
  assign bus.grant_oh = grant_oh_r;
  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;

endmodule

// File: doc/vr_rr_arbiter.md
Name: vr_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready slave channel among N valid/ready masters.
- Each winning master's beat is forwarded to the downstream slave unchanged. The downstream slave is the existing valid/ready slave datapath, which sits after this block.
- Grant is locked from grant until handshake, so a master's valid/data is never cut off mid-beat.
- Fairness: the most recently served requester gets lowest priority on the next arbitration.

Parameters:
- N, 4, number of requesting masters (2..16).
- DW, 8, data width per beat.
- IDW, 2, width of grant_id; must equal clog2(N).
- BURST_MAX, 4, maximum consecutive beats per grant; used only with VR_ARB_BURST_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  N  per-master valid; bit i = master i.
- s_data  input  N*DW  per-master data; master i occupies bits [i*DW +: DW].
- s_ready  output  N  per-master ready; at most one bit high.
- m_valid  output  1  valid to downstream slave.
- m_data  output  DW  data to downstream slave.
- m_ready  input  1  ready from downstream slave.
- grant_oh  output  N  one-hot current grant; all zero when idle.
- grant_id  output  IDW  binary index of the granted master; holds the last winner when idle.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, grant_oh=0, grant_id=N-1, last=N-1, busy=0, beat_cnt=0.
  - Combinationally follows: m_valid=0, m_data=0, s_ready=0.
  - Reset wins over every other event in that cycle; an in-flight beat is abandoned.
- States: IDLE, GRANT.
- IDLE:
  - m_valid=0, m_data=0, s_ready=0, busy=0.
  - If s_valid != 0: select the first set bit scanning from (last+1) mod N upward with wrap.
  - Register grant_oh and grant_id to the winner, then go to GRANT.
  - Latency: 1 cycle from s_valid sampled to grant visible.
- GRANT (g = grant_id):
  - m_valid = s_valid[g], m_data = s_data[g] (combinational mux).
  - s_ready[g] = m_ready; all other s_ready bits are 0.
  - Handshake occurs when s_valid[g] & m_ready. On handshake, last <= g.
  - Base build: after the handshake, go to IDLE.
  - Sustained throughput is therefore 1 beat per 2 cycles under continuous requests.
  - No handshake: stay in GRANT; grant never changes before the handshake.
- Protocol rules required of masters:
  - Once s_valid[i]=1, s_data[i] holds stable until s_ready[i]=1 at a clock edge.
  - Valid never depends on ready.
  - If a granted master drops valid before its handshake (violation), the arbiter stays in GRANT and waits; it does not re-arbitrate.
- Simultaneous requests: ties are broken purely by rotation from last+1.
  - Example: N=4, last=1, s_valid=4'b1011 → master 3 wins.
- Non-granted requesters keep valid asserted and wait; masters are never dropped. Worst-case wait is N grants.
- A new request arriving in the same cycle as a handshake is not seen until IDLE; it is arbitrated on the following edge.

Optional Feature:
- Macro: VR_ARB_BURST_EN.
- Defined:
  - On handshake, beat_cnt increments and state stays GRANT if beat_cnt+1 < BURST_MAX.
  - Subsequent beats from the same master then transfer back-to-back at 1 beat/cycle.
  - Release to IDLE (beat_cnt <= 0) on either of:
    - the handshake that makes beat_cnt+1 == BURST_MAX;
    - any cycle in GRANT with beat_cnt>0 and s_valid[g]=0.
  - last is updated on release.
- Undefined: beat_cnt is absent, BURST_MAX is ignored, and behaviour is exactly the base build (release after every beat).

Test Plan:
- Reset: hold rst=1 for 10 cycles with s_valid=4'b1111 → s_ready=0, m_valid=0, grant_oh=0, grant_id=3, busy=0 throughout.
- Single requester:
  - Stimulus: after reset, master 2 asserts valid with data 8'h0A; m_ready=1.
  - Response: grant_oh=4'b0100 one cycle later; m_data=8'h0A, s_ready[2]=1 in that cycle.
  - Response: busy drops the next cycle.
- Round-robin fairness:
  - Stimulus: all 4 masters assert valid continuously with data 8'h10+i; m_ready=1.
  - Response: grant order is 0,1,2,3,0,...; 8 beats complete in 16 cycles.
- Backpressure: master 1 valid with data 8'h33; m_ready=0 for 5 cycles; master 3 raises valid mid-wait → grant stays on 1, m_data=8'h33 stable, s_ready=0 until m_ready=1; master 3 is granted next.
- Reset mid-operation: rst pulsed while in GRANT with m_ready=0 → the next cycle shows IDLE outputs and grant_id=3; master 0 wins the first arbitration afterwards.
- Burst (VR_ARB_BURST_EN, BURST_MAX=4):
  - Stimulus: master 0 streams 6 beats while master 1 also waits; m_ready=1.
  - Response: master 0 sends 4 back-to-back beats, then master 1 is granted.
  - Response: master 0's remaining 2 beats follow after master 1's burst.
